// File: rtl/alsu_cmd_driver_if.sv
// alsu_cmd_driver_if: command and response streams between a sequencer (master) and alsu_cmd_driver (slave)
interface alsu_cmd_driver_if #(parameter int TAG_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [2:0]       cmd_a;
  logic [2:0]       cmd_b;
  logic [6:0]       cmd_flags;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_out;
  logic             rsp_invalid;
  logic [TAG_W-1:0] rsp_tag;
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_invalid, rsp_tag
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_invalid, rsp_tag
  );
endinterface

// File: rtl/alsu_cmd_driver.sv
// alsu_cmd_driver: queues tagged ALSU commands, issues them under response credit and returns tagged results in order; ALSU_DRV_STATS_EN adds issued/invalid counters
module alsu_cmd_driver #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int LATENCY   = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  alsu_cmd_driver_if.slave bus,
  output logic [2:0]       alsu_opcode,
  output logic [2:0]       alsu_a,
  output logic [2:0]       alsu_b,
  output logic             alsu_cin,
  output logic             alsu_red_op_a,
  output logic             alsu_red_op_b,
  output logic             alsu_bypass_a,
  output logic             alsu_bypass_b,
  output logic             alsu_direction,
  output logic             alsu_serial_in,
`ifdef ALSU_DRV_STATS_EN
  input  logic [5:0]       alsu_out,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      invalid_cnt
`else
  input  logic [5:0]       alsu_out
`endif
);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);
  localparam int CW = TAG_W + 16;
  localparam int RW = TAG_W + 7;
  localparam int PS = LATENCY + 1;
  logic [CW-1:0]    cmem [CMD_DEPTH];
  logic [CA-1:0]    cwr, crd;
  logic [CA:0]      ccnt;
  logic [RW-1:0]    rmem [RSP_DEPTH];
  logic [RA-1:0]    rwr, rrd;
  logic [RA:0]      rcnt;
  logic [TAG_W+1:0] pipe [PS];
  logic [CW-1:0]    head;
  logic [2:0]       h_op;
  logic             h_inv, issue, c_push, r_push, r_pop;
  logic [7:0]       used;
  assign head   = cmem[crd];
  assign h_op   = head[CW-1 -: 3];
  assign h_inv  = ((head[TAG_W+5] | head[TAG_W+4]) & (h_op[1] | h_op[2])) | (h_op[1] & h_op[2]);
  assign c_push = bus.cmd_valid & bus.cmd_ready;
  assign r_push = pipe[PS-1][TAG_W+1];
  assign r_pop  = bus.rsp_valid & bus.rsp_ready;
  assign bus.cmd_ready = ccnt != (CA+1)'(CMD_DEPTH);
  assign bus.rsp_valid = rcnt != '0;
  assign {bus.rsp_out, bus.rsp_invalid, bus.rsp_tag} = rmem[rrd];
  // issue only when queued responses plus commands still in the ALSU leave a free response slot
  always_comb begin
    used = 8'(rcnt);
    for (int i = 0; i < PS; i++) used = used + 8'(pipe[i][TAG_W+1]);
    issue = (ccnt != '0) && (used < 8'(RSP_DEPTH));
  end
  // command FIFO storage; pointers alone define validity so the array needs no reset
  always_ff @(posedge clk)
    if (c_push) cmem[cwr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_flags, bus.cmd_tag};
  // command FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cwr  <= '0;
      crd  <= '0;
      ccnt <= '0;
    end else begin
      cwr  <= cwr + CA'(c_push);
      crd  <= crd + CA'(issue);
      ccnt <= ccnt + (CA+1)'(c_push) - (CA+1)'(issue);
    end
  // ALSU pins take the head command on issue and otherwise hold to keep shift/rotate state
  always_ff @(posedge clk or posedge rst)
    if (rst)
      {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_red_op_a, alsu_red_op_b,
       alsu_bypass_a, alsu_bypass_b, alsu_direction, alsu_serial_in} <= '0;
    else if (issue)
      {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_red_op_a, alsu_red_op_b,
       alsu_bypass_a, alsu_bypass_b, alsu_direction, alsu_serial_in} <= head[CW-1:TAG_W];
  // in-flight slots {valid, invalid, tag} track the ALSU latency; bubbles carry valid=0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < PS; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {issue, h_inv, head[TAG_W-1:0]};
      for (int i = 1; i < PS; i++) pipe[i] <= pipe[i-1];
    end
  // response FIFO captures alsu_out as each valid slot leaves the pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) rmem[i] <= '0;
      rwr  <= '0;
      rrd  <= '0;
      rcnt <= '0;
    end else begin
      if (r_push) rmem[rwr] <= {alsu_out, pipe[PS-1][TAG_W:0]};
      rwr  <= rwr + RA'(r_push);
      rrd  <= rrd + RA'(r_pop);
      rcnt <= rcnt + (RA+1)'(r_push) - (RA+1)'(r_pop);
    end
`ifdef ALSU_DRV_STATS_EN
  // saturating counts of issued commands and of issued invalid combinations
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      issued_cnt  <= '0;
      invalid_cnt <= '0;
    end else if (issue) begin
      issued_cnt  <= issued_cnt + 16'(issued_cnt != '1);
      invalid_cnt <= invalid_cnt + 16'(h_inv && invalid_cnt != '1);
    end
`endif
endmodule
